lap_mem_arb: RTL and testbench
==============================

LAP_MEM_ARB -- requirements
Module: lap_mem_arb

Interface
REQ-001 Parameter P_DEPTH, default 30: number of lap memory entries.
REQ-002 Parameter P_DW, default 28: word width, packed {hour,min,sec,centisec} as 4x7 bits.
REQ-003 Parameter P_AW, default 5: address width.
REQ-004 Parameter P_B_BURST_MAX, default 4: consecutive port-B grants allowed while a port-A refresh is pending.
REQ-005 iClk  in  1  sole clock; all state updates on rising edge.
REQ-006 iRstn  in  1  reset, synchronous, active-low.
REQ-007 iAEn  in  1  port A (stopwatch core) memory enable.
REQ-008 iAWe  in  1  port A write strobe, single cycle.
REQ-009 iAAddr  in  P_AW  port A address; it is a write address when iAWe=1 and a display read address otherwise.
REQ-010 iAWData  in  P_DW  port A write data.
REQ-011 oARData  out  P_DW  shadow copy of mem[iAAddr] for display.
REQ-012 iBReq  in  1  port B (dump/debug) request; held with its attributes until granted.
REQ-013 iBWe  in  1  port B write=1, read=0.
REQ-014 iBAddr  in  P_AW  port B address.
REQ-015 iBWData  in  P_DW  port B write data.
REQ-016 oBGnt  out  1  combinational grant; request is consumed in this cycle.
REQ-017 oBRValid  out  1  one-cycle pulse, port B read data valid.
REQ-018 oBRData  out  P_DW  port B read data.
REQ-019 oBErr  out  1  one-cycle pulse, port B address out of range.
REQ-020 oMemEn, oMemWE  out  1 each  single-port RAM enable and write enable.
REQ-021 oMemAddr  out  P_AW  RAM address.
REQ-022 oMemWData  out  P_DW  RAM write data.
REQ-023 iMemRData  in  P_DW  RAM read data, valid one cycle after a read issue.

Function
REQ-024 Exactly one RAM access per cycle, chosen by priority: A-write (iAEn&iAWe), then B, then A-refresh read.
REQ-025 An A-write is never stalled; in the same cycle, oBGnt=0 and pending B retries.
REQ-026 B is granted when no A-write is present and either rStale=0 or rBurst<P_B_BURST_MAX; otherwise an A-refresh read issues at iAAddr.
REQ-027 rStale sets on any of: iAAddr change while iAEn=1; A-write; B-write to the address currently in iAAddr; iAEn rising edge. rStale clears one cycle after an A-refresh issue, unless a new set event occurred in the issue cycle or the issue cycle itself.
REQ-028 rBurst increments on each B grant while rStale=1 (saturating at P_B_BURST_MAX); it clears on A-refresh issue or when rStale=0.
REQ-029 oARData loads iMemRData in the cycle after an A-refresh issue; otherwise it holds.
REQ-030 B read: issue in the grant cycle; oBRValid=1 with oBRData=iMemRData in the following cycle. B write produces no response pulse.
REQ-031 B with iBAddr>=P_DEPTH: oBGnt=1, no RAM access (oMemEn=0), oBErr=1 in the next cycle; that slot is then free for an A-refresh in the same cycle.
REQ-032 A read tracking uses a one-bit registered owner tag (A/B) per issued read; there are no other latency paths.
REQ-033 When nothing is issued: oMemEn=0, oMemWE=0, oMemAddr=0, oMemWData=0.

Reset
REQ-034 While iRstn=0 at a clock edge: oARData=0, oBRValid=0, oBRData=0, oBErr=0, rStale=1, rBurst=0, owner tag cleared.
REQ-035 While iRstn=0: oBGnt=0 and oMemEn=0 combinationally.
REQ-036 A read in flight at reset is discarded.

Structure
REQ-037 P_DEPTH, P_DW, P_AW and the field bit positions SHALL live in shared package lap_mem_pkg, also used by the stopwatch core.
REQ-038 The combinational priority selector SHALL be sub-module lap_arb_grant; tag, stale and burst registers stay in the top module.

Verification
REQ-039 Reset release, iAEn=1, iAAddr=3, mem[3]=0x0012345 -> refresh issued on first cycle, oARData=0x0012345 two cycles after release.
REQ-040 iAWe=1 addr 5 and iBReq read addr 7 in the same cycle -> oMemWE=1 addr 5, oBGnt=0; next cycle oBGnt=1; one cycle later oBRValid=1 with mem[7].
REQ-041 rStale=1, continuous B reads -> exactly 4 B grants, then 1 A-refresh, then B resumes.
REQ-042 B write addr 3 with data 0xABCDEF0 while iAAddr=3 -> oARData=0xABCDEF0 within 3 cycles.
REQ-043 B read addr 30 -> oBGnt=1, oMemEn=0, oBErr=1 next cycle, oBRValid stays 0.
REQ-044 iRstn=0 asserted the cycle after a B read grant -> oBRValid stays 0, all outputs at reset values.

Source files
------------

// File: rtl/lap_mem_pkg.sv
// ----------------------------------------------------------------------------
// lap_mem_pkg
// Shared constants for the lap memory: depth, word width, address width,
// port-B burst limit and the bit positions of the packed time fields
// {hour, min, sec, centisec}. Used by the stopwatch core and by lap_mem_arb.
// Also holds the arbiter's access-source and read-owner enums.
// ----------------------------------------------------------------------------
package lap_mem_pkg;

    localparam int P_DEPTH       = 30;
    localparam int P_DW          = 28;
    localparam int P_AW          = 5;
    localparam int P_B_BURST_MAX = 4;

    // Each time field is 7 bits wide; centiseconds sit in the LSBs.
    localparam int FIELD_W      = 7;
    localparam int CENTISEC_LSB = 0;
    localparam int SEC_LSB      = 7;
    localparam int MIN_LSB      = 14;
    localparam int HOUR_LSB     = 21;

    typedef struct packed {
        logic [FIELD_W-1:0] hour;
        logic [FIELD_W-1:0] minute;
        logic [FIELD_W-1:0] second;
        logic [FIELD_W-1:0] centisec;
    } lap_time_t;

    // Which requester owns the single RAM slot in the current cycle.
    typedef enum logic [1:0] {
        SRC_NONE  = 2'd0,
        SRC_A_WR  = 2'd1,
        SRC_B     = 2'd2,
        SRC_A_REF = 2'd3
    } src_e;

    // Who receives the data of a read issued last cycle.
    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

    function automatic lap_time_t word_to_time(input logic [P_DW-1:0] word);
        lap_time_t t;
        t.hour     = word[HOUR_LSB     +: FIELD_W];
        t.minute   = word[MIN_LSB      +: FIELD_W];
        t.second   = word[SEC_LSB      +: FIELD_W];
        t.centisec = word[CENTISEC_LSB +: FIELD_W];
        return t;
    endfunction

endpackage

// File: rtl/lap_mem_arb_if.sv
// ----------------------------------------------------------------------------
// lap_mem_arb_if
// Bus bundle of the lap memory arbiter:
//   port A  : stopwatch core write strobe + display shadow read-back
//   port B  : dump/debug request/grant with read response and range error
//   memory  : single-port RAM command and read data
// Modports: slave = the arbiter, master = its environment (core, debug, RAM).
// ----------------------------------------------------------------------------
interface lap_mem_arb_if #(
    parameter int P_AW = lap_mem_pkg::P_AW,
    parameter int P_DW = lap_mem_pkg::P_DW
);
    // Port A
    logic            iAEn;
    logic            iAWe;
    logic [P_AW-1:0] iAAddr;
    logic [P_DW-1:0] iAWData;
    logic [P_DW-1:0] oARData;
    // Port B
    logic            iBReq;
    logic            iBWe;
    logic [P_AW-1:0] iBAddr;
    logic [P_DW-1:0] iBWData;
    logic            oBGnt;
    logic            oBRValid;
    logic [P_DW-1:0] oBRData;
    logic            oBErr;
    // RAM
    logic            oMemEn;
    logic            oMemWE;
    logic [P_AW-1:0] oMemAddr;
    logic [P_DW-1:0] oMemWData;
    logic [P_DW-1:0] iMemRData;

    modport slave (
        input  iAEn, iAWe, iAAddr, iAWData,
        output oARData,
        input  iBReq, iBWe, iBAddr, iBWData,
        output oBGnt, oBRValid, oBRData, oBErr,
        output oMemEn, oMemWE, oMemAddr, oMemWData,
        input  iMemRData
    );

    modport master (
        output iAEn, iAWe, iAAddr, iAWData,
        input  oARData,
        output iBReq, iBWe, iBAddr, iBWData,
        input  oBGnt, oBRValid, oBRData, oBErr,
        input  oMemEn, oMemWE, oMemAddr, oMemWData,
        output iMemRData
    );

endinterface

// File: rtl/lap_arb_grant.sv
// ----------------------------------------------------------------------------
// lap_arb_grant
// Combinational priority selector for the single RAM slot.
// Priority: A-write, then B (subject to the burst limit while A is stale),
// then A-refresh read. An out-of-range B is granted without touching the RAM,
// leaving the slot to an A-refresh.
// Ports:
//   run            : low forces no grant and no RAM access (reset)
//   a_*            : port A enable/write/address/data
//   b_*            : port B request/write/address/data
//   stale, burst_ok: shadow-stale flag and "burst budget left" from the top
//   b_gnt, b_in_range, src : grant, range check, slot owner
//   mem_*          : RAM command
// ----------------------------------------------------------------------------
module lap_arb_grant
    import lap_mem_pkg::*;
#(
    parameter int P_DEPTH = lap_mem_pkg::P_DEPTH,
    parameter int P_DW    = lap_mem_pkg::P_DW,
    parameter int P_AW    = lap_mem_pkg::P_AW
) (
    input  logic            run,
    input  logic            a_en,
    input  logic            a_we,
    input  logic [P_AW-1:0] a_addr,
    input  logic [P_DW-1:0] a_wdata,
    input  logic            b_req,
    input  logic            b_we,
    input  logic [P_AW-1:0] b_addr,
    input  logic [P_DW-1:0] b_wdata,
    input  logic            stale,
    input  logic            burst_ok,
    output logic            b_gnt,
    output logic            b_in_range,
    output src_e            src,
    output logic            mem_en,
    output logic            mem_we,
    output logic [P_AW-1:0] mem_addr,
    output logic [P_DW-1:0] mem_wdata
);

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path
        // through this block can leave a value held (no inferred latch).
        b_gnt      = 1'b0;
        src        = SRC_NONE;
        b_in_range = (32'(b_addr) < P_DEPTH);

        if (run) begin
            if (a_en && a_we) begin
                src = SRC_A_WR;
            end else if (b_req && (!stale || burst_ok)) begin
                b_gnt = 1'b1;
                if (b_in_range) begin
                    src = SRC_B;
                end else if (stale) begin
                    src = SRC_A_REF;
                end
            end else if (stale) begin
                src = SRC_A_REF;
            end
        end

        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (src)
            SRC_A_WR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = a_addr;
                mem_wdata = a_wdata;
            end
            SRC_B: begin
                mem_en    = 1'b1;
                mem_we    = b_we;
                mem_addr  = b_addr;
                mem_wdata = b_we ? b_wdata : '0;
            end
            SRC_A_REF: begin
                mem_en   = 1'b1;
                mem_addr = a_addr;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lap_mem_arb.sv
// ----------------------------------------------------------------------------
// lap_mem_arb
// Shares one single-port lap RAM between the stopwatch core (port A) and a
// dump/debug port (port B). Port A writes are never stalled; port A also owns
// a shadow register (oARData) that is refreshed from mem[iAAddr] whenever it
// may be out of date. Port B is throttled to P_B_BURST_MAX grants while a
// refresh is pending.
// Ports:
//   iClk  : clock, rising edge
//   iRstn : synchronous active-low reset
//   bus   : lap_mem_arb_if.slave (port A, port B, RAM)
// ----------------------------------------------------------------------------
module lap_mem_arb
    import lap_mem_pkg::*;
#(
    parameter int P_DEPTH       = lap_mem_pkg::P_DEPTH,
    parameter int P_DW          = lap_mem_pkg::P_DW,
    parameter int P_AW          = lap_mem_pkg::P_AW,
    parameter int P_B_BURST_MAX = lap_mem_pkg::P_B_BURST_MAX
) (
    input logic          iClk,
    input logic          iRstn,
    lap_mem_arb_if.slave bus
);

    localparam int BURST_W = $clog2(P_B_BURST_MAX + 1);

    logic               stale;
    logic [BURST_W-1:0] burst;
    logic               rd_pend;
    owner_e             rd_owner;
    logic               prev_en;
    logic [P_AW-1:0]    prev_addr;
    logic [P_DW-1:0]    ar_data;
    logic               b_err_q;

    logic               burst_ok;
    logic               b_gnt;
    logic               b_in_range;
    src_e               src;
    logic               refresh;
    logic               set_evt;
    logic               b_rvalid;

    assign burst_ok = (32'(burst) < P_B_BURST_MAX);

    lap_arb_grant #(
        .P_DEPTH (P_DEPTH),
        .P_DW    (P_DW),
        .P_AW    (P_AW)
    ) u_grant (
        .run        (iRstn),
        .a_en       (bus.iAEn),
        .a_we       (bus.iAWe),
        .a_addr     (bus.iAAddr),
        .a_wdata    (bus.iAWData),
        .b_req      (bus.iBReq),
        .b_we       (bus.iBWe),
        .b_addr     (bus.iBAddr),
        .b_wdata    (bus.iBWData),
        .stale      (stale),
        .burst_ok   (burst_ok),
        .b_gnt      (b_gnt),
        .b_in_range (b_in_range),
        .src        (src),
        .mem_en     (bus.oMemEn),
        .mem_we     (bus.oMemWE),
        .mem_addr   (bus.oMemAddr),
        .mem_wdata  (bus.oMemWData)
    );

    assign refresh = (src == SRC_A_REF);

    // Anything that can make the shadow differ from mem[iAAddr]: the
    // displayed address moved, the core wrote, B overwrote the displayed
    // entry, or the core just came up.
    assign set_evt = (bus.iAEn && (bus.iAAddr != prev_addr))
                   || (bus.iAEn && bus.iAWe)
                   || ((src == SRC_B) && bus.iBWe && (bus.iBAddr == bus.iAAddr))
                   || (bus.iAEn && !prev_en);

    always_ff @(posedge iClk) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (!iRstn) begin
            stale     <= 1'b1;
            burst     <= '0;
            rd_pend   <= 1'b0;
            rd_owner  <= OWN_A;
            prev_en   <= 1'b0;
            prev_addr <= '0;
            ar_data   <= '0;
            b_err_q   <= 1'b0;
        end else begin
            prev_en   <= bus.iAEn;
            prev_addr <= bus.iAAddr;

            if (set_evt) begin
                stale <= 1'b1;
            end else if (refresh) begin
                stale <= 1'b0;
            end

            if (refresh || !stale) begin
                burst <= '0;
            end else if (b_gnt && burst_ok) begin
                burst <= burst + 1'b1;
            end

            rd_pend  <= refresh || ((src == SRC_B) && !bus.iBWe);
            rd_owner <= (src == SRC_B) ? OWN_B : OWN_A;

            if (rd_pend && (rd_owner == OWN_A)) begin
                ar_data <= bus.iMemRData;
            end

            b_err_q <= b_gnt && !b_in_range;
        end
    end

    // RAM data arrives the cycle after issue, so the B response is steered
    // straight through; gating with iRstn drops a read in flight at reset.
    assign b_rvalid     = iRstn && rd_pend && (rd_owner == OWN_B);
    assign bus.oBRValid = b_rvalid;
    assign bus.oBRData  = b_rvalid ? bus.iMemRData : '0;
    assign bus.oBErr    = iRstn && b_err_q;
    assign bus.oBGnt    = b_gnt;
    assign bus.oARData  = ar_data;

endmodule

// File: tb/tb_lap_mem_arb.sv
// ----------------------------------------------------------------------------
// tb_lap_mem_arb
// Self-checking bench for lap_mem_arb: a behavioural single-port RAM, a
// table of per-cycle input/expected-output records, and hand-written
// sequences for reset release, shadow refresh and reset during a B read.
// ----------------------------------------------------------------------------
module tb_lap_mem_arb;
    import lap_mem_pkg::*;

    localparam int AW = P_AW;
    localparam int DW = P_DW;

    localparam logic [DW-1:0] MB = 28'h0345600;  // mem[i] = MB + i
    localparam logic [DW-1:0] D3 = 28'h0012345;  // mem[3] override
    localparam logic [DW-1:0] X1 = 28'h1234567;
    localparam logic [DW-1:0] XB = 28'hABCDEF0;
    localparam logic [DW-1:0] X2 = 28'h0FEDCBA;
    localparam logic [DW-1:0] Z  = '0;
    localparam int            N_VEC = 24;

    typedef struct packed {
        logic          a_en;
        logic          a_we;
        logic [AW-1:0] a_addr;
        logic [DW-1:0] a_wdata;
        logic          b_req;
        logic          b_we;
        logic [AW-1:0] b_addr;
        logic [DW-1:0] b_wdata;
    } in_t;

    typedef struct packed {
        logic          gnt;
        logic          en;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic          rv;
        logic [DW-1:0] rd;
        logic          err;
        logic [DW-1:0] ar;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic preload;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [DW-1:0] ram [32];
    logic [DW-1:0] ram_rdata;

    in_t  ins  [N_VEC];
    exp_t exps [N_VEC];

    lap_mem_arb_if #(.P_AW(AW), .P_DW(DW)) bus ();

    lap_mem_arb u_dut (
        .iClk  (clk),
        .iRstn (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) ram[i] <= MB + 28'(i);
            ram[3] <= D3;
        end else if (bus.oMemEn) begin
            if (bus.oMemWE) ram[bus.oMemAddr] <= bus.oMemWData;
            else            ram_rdata <= ram[bus.oMemAddr];
        end
    end
    assign bus.iMemRData = ram_rdata;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chk5(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk28(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%07h expected 0x%07h", name, act, exp);
        end
    endtask

    function automatic in_t mk_in(input logic a_en, input logic a_we,
                                  input logic [AW-1:0] a_addr, input logic [DW-1:0] a_wdata,
                                  input logic b_req, input logic b_we,
                                  input logic [AW-1:0] b_addr, input logic [DW-1:0] b_wdata);
        in_t v;
        v.a_en = a_en; v.a_we = a_we; v.a_addr = a_addr; v.a_wdata = a_wdata;
        v.b_req = b_req; v.b_we = b_we; v.b_addr = b_addr; v.b_wdata = b_wdata;
        return v;
    endfunction

    function automatic exp_t mk_exp(input logic gnt, input logic en, input logic we,
                                    input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                                    input logic rv, input logic [DW-1:0] rd,
                                    input logic err, input logic [DW-1:0] ar);
        exp_t e;
        e.gnt = gnt; e.en = en; e.we = we; e.addr = addr; e.wd = wd;
        e.rv = rv; e.rd = rd; e.err = err; e.ar = ar;
        return e;
    endfunction

    task automatic apply(input in_t v);
        bus.iAEn    = v.a_en;
        bus.iAWe    = v.a_we;
        bus.iAAddr  = v.a_addr;
        bus.iAWData = v.a_wdata;
        bus.iBReq   = v.b_req;
        bus.iBWe    = v.b_we;
        bus.iBAddr  = v.b_addr;
        bus.iBWData = v.b_wdata;
    endtask

    initial begin
        // Cycle 0 is the first cycle after reset release: rStale=1, iAEn=0.
        ins[0]  = mk_in(1'b0, 1'b0, 5'd0, Z, 1'b1, 1'b0, 5'd1, Z);
        exps[0] = mk_exp(1'b1, 1'b1, 1'b0, 5'd1, Z, 1'b0, Z, 1'b0, Z);
        ins[1]  = mk_in(1'b0, 1'b0, 5'd0, Z, 1'b1, 1'b0, 5'd2, Z);
        exps[1] = mk_exp(1'b1, 1'b1, 1'b0, 5'd2, Z, 1'b1, MB + 28'd1, 1'b0, Z);
        ins[2]  = mk_in(1'b0, 1'b0, 5'd0, Z, 1'b1, 1'b0, 5'd3, Z);
        exps[2] = mk_exp(1'b1, 1'b1, 1'b0, 5'd3, Z, 1'b1, MB + 28'd2, 1'b0, Z);
        ins[3]  = mk_in(1'b0, 1'b0, 5'd0, Z, 1'b1, 1'b0, 5'd4, Z);
        exps[3] = mk_exp(1'b1, 1'b1, 1'b0, 5'd4, Z, 1'b1, D3, 1'b0, Z);
        // Burst of 4 used up: refresh at iAAddr=0 takes the slot.
        ins[4]  = mk_in(1'b0, 1'b0, 5'd0, Z, 1'b1, 1'b0, 5'd5, Z);
        exps[4] = mk_exp(1'b0, 1'b1, 1'b0, 5'd0, Z, 1'b1, MB + 28'd4, 1'b0, Z);
        ins[5]  = mk_in(1'b0, 1'b0, 5'd0, Z, 1'b1, 1'b0, 5'd5, Z);
        exps[5] = mk_exp(1'b1, 1'b1, 1'b0, 5'd5, Z, 1'b0, Z, 1'b0, Z);
        ins[6]  = mk_in(1'b0, 1'b0, 5'd0, Z, 1'b1, 1'b0, 5'd6, Z);
        exps[6] = mk_exp(1'b1, 1'b1, 1'b0, 5'd6, Z, 1'b1, MB + 28'd5, 1'b0, MB);
        ins[7]  = mk_in(1'b0, 1'b0, 5'd0, Z, 1'b0, 1'b0, 5'd0, Z);
        exps[7] = mk_exp(1'b0, 1'b0, 1'b0, 5'd0, Z, 1'b1, MB + 28'd6, 1'b0, MB);
        // A-write beats a pending B read, B follows next cycle.
        ins[8]  = mk_in(1'b1, 1'b1, 5'd5, X1, 1'b1, 1'b0, 5'd7, Z);
        exps[8] = mk_exp(1'b0, 1'b1, 1'b1, 5'd5, X1, 1'b0, Z, 1'b0, MB);
        ins[9]  = mk_in(1'b1, 1'b0, 5'd5, Z, 1'b1, 1'b0, 5'd7, Z);
        exps[9] = mk_exp(1'b1, 1'b1, 1'b0, 5'd7, Z, 1'b0, Z, 1'b0, MB);
        ins[10]  = mk_in(1'b1, 1'b0, 5'd5, Z, 1'b0, 1'b0, 5'd0, Z);
        exps[10] = mk_exp(1'b0, 1'b1, 1'b0, 5'd5, Z, 1'b1, MB + 28'd7, 1'b0, MB);
        ins[11]  = mk_in(1'b1, 1'b0, 5'd5, Z, 1'b0, 1'b0, 5'd0, Z);
        exps[11] = mk_exp(1'b0, 1'b0, 1'b0, 5'd0, Z, 1'b0, Z, 1'b0, MB);
        // B write to the displayed address forces a refresh.
        ins[12]  = mk_in(1'b1, 1'b0, 5'd5, Z, 1'b1, 1'b1, 5'd5, XB);
        exps[12] = mk_exp(1'b1, 1'b1, 1'b1, 5'd5, XB, 1'b0, Z, 1'b0, X1);
        ins[13]  = mk_in(1'b1, 1'b0, 5'd5, Z, 1'b0, 1'b0, 5'd0, Z);
        exps[13] = mk_exp(1'b0, 1'b1, 1'b0, 5'd5, Z, 1'b0, Z, 1'b0, X1);
        ins[14]  = mk_in(1'b1, 1'b0, 5'd5, Z, 1'b0, 1'b0, 5'd0, Z);
        exps[14] = mk_exp(1'b0, 1'b0, 1'b0, 5'd0, Z, 1'b0, Z, 1'b0, X1);
        ins[15]  = mk_in(1'b1, 1'b0, 5'd5, Z, 1'b0, 1'b0, 5'd0, Z);
        exps[15] = mk_exp(1'b0, 1'b0, 1'b0, 5'd0, Z, 1'b0, Z, 1'b0, XB);
        // Out-of-range B read with nothing stale: grant, no RAM access.
        ins[16]  = mk_in(1'b1, 1'b0, 5'd5, Z, 1'b1, 1'b0, 5'd30, Z);
        exps[16] = mk_exp(1'b1, 1'b0, 1'b0, 5'd0, Z, 1'b0, Z, 1'b0, XB);
        ins[17]  = mk_in(1'b1, 1'b0, 5'd5, Z, 1'b0, 1'b0, 5'd0, Z);
        exps[17] = mk_exp(1'b0, 1'b0, 1'b0, 5'd0, Z, 1'b0, Z, 1'b1, XB);
        ins[18]  = mk_in(1'b1, 1'b0, 5'd5, Z, 1'b0, 1'b0, 5'd0, Z);
        exps[18] = mk_exp(1'b0, 1'b0, 1'b0, 5'd0, Z, 1'b0, Z, 1'b0, XB);
        // Address change makes A stale; out-of-range B then shares the cycle
        // with the refresh.
        ins[19]  = mk_in(1'b1, 1'b0, 5'd2, Z, 1'b0, 1'b0, 5'd0, Z);
        exps[19] = mk_exp(1'b0, 1'b0, 1'b0, 5'd0, Z, 1'b0, Z, 1'b0, XB);
        ins[20]  = mk_in(1'b1, 1'b0, 5'd2, Z, 1'b1, 1'b0, 5'd31, Z);
        exps[20] = mk_exp(1'b1, 1'b1, 1'b0, 5'd2, Z, 1'b0, Z, 1'b0, XB);
        ins[21]  = mk_in(1'b1, 1'b0, 5'd2, Z, 1'b0, 1'b0, 5'd0, Z);
        exps[21] = mk_exp(1'b0, 1'b0, 1'b0, 5'd0, Z, 1'b0, Z, 1'b1, XB);
        // B write elsewhere leaves the shadow alone.
        ins[22]  = mk_in(1'b1, 1'b0, 5'd2, Z, 1'b1, 1'b1, 5'd9, X2);
        exps[22] = mk_exp(1'b1, 1'b1, 1'b1, 5'd9, X2, 1'b0, Z, 1'b0, MB + 28'd2);
        ins[23]  = mk_in(1'b1, 1'b0, 5'd2, Z, 1'b0, 1'b0, 5'd0, Z);
        exps[23] = mk_exp(1'b0, 1'b0, 1'b0, 5'd0, Z, 1'b0, Z, 1'b0, MB + 28'd2);

        // ---- Reset, then release with iAEn=1, iAAddr=3 ----
        rst_n   = 1'b0;
        preload = 1'b1;
        apply(mk_in(1'b1, 1'b0, 5'd3, Z, 1'b1, 1'b0, 5'd1, Z));
        repeat (3) @(posedge clk);
        @(negedge clk);
        preload = 1'b0;
        #1;
        chk1 ("rst gnt",     bus.oBGnt,    1'b0);
        chk1 ("rst mem_en",  bus.oMemEn,   1'b0);
        chk28("rst ar_data", bus.oARData,  Z);
        chk1 ("rst rvalid",  bus.oBRValid, 1'b0);
        chk28("rst rdata",   bus.oBRData,  Z);
        chk1 ("rst err",     bus.oBErr,    1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        apply(mk_in(1'b1, 1'b0, 5'd3, Z, 1'b0, 1'b0, 5'd0, Z));
        #1;
        chk1 ("rel0 mem_en",   bus.oMemEn,   1'b1);
        chk1 ("rel0 mem_we",   bus.oMemWE,   1'b0);
        chk5 ("rel0 mem_addr", bus.oMemAddr, 5'd3);
        chk1 ("rel0 gnt",      bus.oBGnt,    1'b0);
        @(negedge clk);
        #1;
        chk28("rel1 ar_data",  bus.oARData,  Z);
        @(negedge clk);
        #1;
        chk28("rel2 ar_data",  bus.oARData,  D3);
        chk1 ("rel2 mem_en",   bus.oMemEn,   1'b0);

        // ---- Re-reset with iAEn=0, then run the vector table ----
        @(negedge clk);
        rst_n = 1'b0;
        apply(mk_in(1'b0, 1'b0, 5'd0, Z, 1'b0, 1'b0, 5'd0, Z));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N_VEC; i++) begin
            apply(ins[i]);
            #1;
            chk1 ($sformatf("v%0d gnt", i),      bus.oBGnt,    exps[i].gnt);
            chk1 ($sformatf("v%0d mem_en", i),   bus.oMemEn,   exps[i].en);
            chk1 ($sformatf("v%0d mem_we", i),   bus.oMemWE,   exps[i].we);
            chk5 ($sformatf("v%0d mem_addr", i), bus.oMemAddr, exps[i].addr);
            if (!exps[i].en || exps[i].we)
                chk28($sformatf("v%0d mem_wdata", i), bus.oMemWData, exps[i].wd);
            chk1 ($sformatf("v%0d rvalid", i),   bus.oBRValid, exps[i].rv);
            if (exps[i].rv)
                chk28($sformatf("v%0d rdata", i), bus.oBRData, exps[i].rd);
            chk1 ($sformatf("v%0d err", i),      bus.oBErr,    exps[i].err);
            chk28($sformatf("v%0d ar_data", i),  bus.oARData,  exps[i].ar);
            @(negedge clk);
        end

        // ---- Reset asserted the cycle after a B read grant ----
        apply(mk_in(1'b0, 1'b0, 5'd0, Z, 1'b1, 1'b0, 5'd1, Z));
        #1;
        chk1 ("rstb gnt",      bus.oBGnt,    1'b1);
        chk5 ("rstb mem_addr", bus.oMemAddr, 5'd1);
        @(negedge clk);
        rst_n = 1'b0;
        apply(mk_in(1'b0, 1'b0, 5'd0, Z, 1'b0, 1'b0, 5'd0, Z));
        #1;
        chk1 ("rstb0 rvalid",  bus.oBRValid, 1'b0);
        chk28("rstb0 rdata",   bus.oBRData,  Z);
        chk1 ("rstb0 mem_en",  bus.oMemEn,   1'b0);
        @(negedge clk);
        #1;
        chk1 ("rstb1 rvalid",  bus.oBRValid, 1'b0);
        chk1 ("rstb1 err",     bus.oBErr,    1'b0);
        chk28("rstb1 ar_data", bus.oARData,  Z);
        rst_n = 1'b1;
        #1;
        // Stale is set by reset, so the first free cycle refreshes iAAddr=0.
        chk1 ("post mem_en",   bus.oMemEn,   1'b1);
        chk5 ("post mem_addr", bus.oMemAddr, 5'd0);
        @(negedge clk);
        #1;
        chk1 ("post rvalid",   bus.oBRValid, 1'b0);
        chk1 ("post mem_en2",  bus.oMemEn,   1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
